// File: rtl/lfsr_range_timer.sv
// Random-duration countdown timer: a free-running Galois LFSR picks a start value in
// [MIN_VAL, MIN_VAL+SPAN-1], which is then counted down at CLK_HZ/TICK_HZ.
module lfsr_range_timer #(
    parameter int                CLK_HZ    = 100_000_000,
    parameter int                TICK_HZ   = 1,
    parameter int                CNT_W     = 6,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] TAPS      = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED      = 8'h5A,
    parameter int                MIN_VAL   = 20,
    parameter int                SPAN      = 11,
    parameter bit                RETRIGGER = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] start_value,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    // An all-zero register would lock up the Galois LFSR, so it is re-seeded.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        if (v == '0) begin
            return SEED;
        end else begin
            return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? TAPS : {LFSR_W{1'b0}});
        end
    endfunction

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  sv_q, sv_d;
    logic              busy_q, busy_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  candidate_s;

    assign candidate_s = CNT_W'(32'(MIN_VAL) + (32'(lfsr_q) % 32'(SPAN)));

    // Next-state logic; busy is held through the done cycle and drops one cycle later.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        sv_d    = sv_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d  = 1'b0;
                count_d = '0;
                if (start && !abort) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    count_d = candidate_s;
                    sv_d    = candidate_s;
                    busy_d  = 1'b1;
                end else begin
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (RETRIGGER && start) begin
                    presc_d = '0;
                    count_d = candidate_s;
                    sv_d    = candidate_s;
                end else if (!pause) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        count_d = count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end else begin
                    presc_d = presc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                count_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, LFSR and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            presc_q <= '0;
            count_q <= '0;
            sv_q    <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_step(lfsr_q);
            presc_q <= presc_d;
            count_q <= count_d;
            sv_q    <= sv_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign count       = count_q;
    assign start_value = sv_q;
    assign busy        = busy_q;
    assign tick        = tick_q;
    assign done        = done_q;

endmodule

// File: tb/tb_lfsr_range_timer.sv
// Directed bench for lfsr_range_timer: DUT A uses SPAN=11/no retrigger, DUT B SPAN=1/retrigger.
module tb_lfsr_range_timer;

    localparam int         MINV = 20;
    localparam logic [7:0] SEED = 8'h5A;
    localparam logic [7:0] TAPS = 8'hB8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_start = 1'b0, a_pause = 1'b0, a_abort = 1'b0;
    logic       b_start = 1'b0, b_pause = 1'b0, b_abort = 1'b0;
    logic [5:0] a_count, a_start_value, b_count, b_start_value;
    logic       a_busy, a_tick, a_done, b_busy, b_tick, b_done;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] m_lfsr = 8'h00;
    int         exp_q[$];

    always #5 clk = ~clk;

    lfsr_range_timer #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(6), .LFSR_W(8), .TAPS(TAPS),
                       .SEED(SEED), .MIN_VAL(MINV), .SPAN(11), .RETRIGGER(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .pause(a_pause), .abort(a_abort),
        .count(a_count), .start_value(a_start_value), .busy(a_busy), .tick(a_tick), .done(a_done)
    );

    lfsr_range_timer #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(6), .LFSR_W(8), .TAPS(TAPS),
                       .SEED(SEED), .MIN_VAL(MINV), .SPAN(1), .RETRIGGER(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .pause(b_pause), .abort(b_abort),
        .count(b_count), .start_value(b_start_value), .busy(b_busy), .tick(b_tick), .done(b_done)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        if (v == 8'h00) return SEED;
        return {1'b0, v[7:1]} ^ (v[0] ? TAPS : 8'h00);
    endfunction

    function automatic int cand(input int span);
        return MINV + (int'(m_lfsr) % span);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        check(tag, obs, exp);
    endtask

    // One clock: the model LFSR advances on the same edge as the DUTs.
    task automatic step();
        @(posedge clk);
        m_lfsr = reset ? SEED : lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic start_a(output int v);
        a_start = 1'b1;
        v = cand(11);
        exp_q.push_back(v);
        step();
        a_start = 1'b0;
        sb_check("a_start_value", 32'(a_start_value));
    endtask

    task automatic start_b();
        b_start = 1'b1;
        exp_q.push_back(cand(1));
        step();
        b_start = 1'b0;
        sb_check("b_start_value", 32'(b_start_value));
        check("b_count_load", 32'(b_count), 32'd20);
        check("b_busy_load", 32'(b_busy), 32'd1);
    endtask

    // Runs DUT B (start value 20, DIV 10) with pause high on edges lo..hi.
    task automatic run_b(input int k_end, input int lo, input int hi);
        int e;
        bit paused, tk;
        e = 0;
        for (int k = 1; k <= k_end; k++) begin
            paused  = (k >= lo) && (k <= hi);
            b_pause = paused;
            step();
            if (!paused) e++;
            tk = !paused && (e > 0) && (e % 10 == 0) && (e <= 200);
            check("b_tick", 32'(b_tick), 32'(tk));
            check("b_count", 32'(b_count), (e >= 200) ? 32'd0 : 32'(20 - e / 10));
            check("b_done", 32'(b_done), 32'(tk && (e == 200)));
            check("b_busy", 32'(b_busy), (e <= 200) ? 32'd1 : 32'd0);
        end
        b_pause = 1'b0;
    endtask

    initial begin
        int v, v2, v3, gap, sv, distinct;
        bit seen[11];

        step();
        step();
        reset = 1'b0;
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_a_sv", 32'(a_start_value), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_tick", 32'(a_tick), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);

        // Full countdown from 20, done at cycle 200, busy low at 201.
        start_b();
        run_b(201, 1, 0);

        // Pause of 37 cycles with count 5 mid-period delays done to cycle 237.
        start_b();
        run_b(238, 154, 190);
        check("b_sv_after_pause", 32'(b_start_value), 32'd20);

        // Retrigger coincident with the final tick.
        start_b();
        run_b(199, 1, 0);
        b_start = 1'b1;
        exp_q.push_back(cand(1));
        step();
        b_start = 1'b0;
        check("retrig_done", 32'(b_done), 32'd0);
        check("retrig_tick", 32'(b_tick), 32'd0);
        check("retrig_count", 32'(b_count), 32'd20);
        check("retrig_busy", 32'(b_busy), 32'd1);
        sb_check("retrig_sv", 32'(b_start_value));
        repeat (9) step();
        check("retrig_no_early_tick", 32'(b_tick), 32'd0);
        check("retrig_count_hold", 32'(b_count), 32'd20);
        step();
        check("retrig_first_tick", 32'(b_tick), 32'd1);
        check("retrig_count_dec", 32'(b_count), 32'd19);
        b_abort = 1'b1;
        step();
        b_abort = 1'b0;
        check("b_abort_busy", 32'(b_busy), 32'd0);

        // Abort at count 3.
        start_a(v);
        repeat ((v - 3) * 10 + 4) step();
        check("a_count_3", 32'(a_count), 32'd3);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_count", 32'(a_count), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_tick", 32'(a_tick), 32'd0);
        check("abort_sv", 32'(a_start_value), 32'(v));
        for (int i = 0; i < 40; i++) begin
            step();
            check("abort_no_done", 32'(a_done | a_tick), 32'd0);
        end

        // Abort together with start in IDLE.
        a_abort = 1'b1;
        a_start = 1'b1;
        step();
        a_abort = 1'b0;
        a_start = 1'b0;
        check("abst_busy", 32'(a_busy), 32'd0);
        check("abst_count", 32'(a_count), 32'd0);
        check("abst_sv", 32'(a_start_value), 32'(v));

        // Start while running is ignored without retrigger.
        start_a(v2);
        repeat ((v2 - 7) * 10 + 3) step();
        check("a_count_7", 32'(a_count), 32'd7);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("noretrig_count", 32'(a_count), 32'd7);
        check("noretrig_sv", 32'(a_start_value), 32'(v2));
        check("noretrig_busy", 32'(a_busy), 32'd1);
        repeat (6) step();
        check("noretrig_tick", 32'(a_tick), 32'd1);
        check("noretrig_count6", 32'(a_count), 32'd6);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;

        // Synchronous reset mid-run at count 12.
        start_a(v3);
        repeat ((v3 - 12) * 10 + 5) step();
        check("a_count_12", 32'(a_count), 32'd12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_count", 32'(a_count), 32'd0);
        check("mrst_sv", 32'(a_start_value), 32'd0);
        check("mrst_busy", 32'(a_busy), 32'd0);
        check("mrst_tick", 32'(a_tick), 32'd0);
        check("mrst_done", 32'(a_done), 32'd0);
        start_a(v);
        check("mrst_seed_cand", 32'(a_start_value), 32'd22);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;

        // Random start times: values track the LFSR model and cover the whole range.
        for (int i = 0; i < 1000; i++) begin
            start_a(sv);
            check("rand_in_range", 32'((a_start_value >= 6'd20) && (a_start_value <= 6'd30)), 32'd1);
            if (sv >= 20 && sv <= 30) seen[sv - 20] = 1'b1;
            a_abort = 1'b1;
            step();
            a_abort = 1'b0;
            gap = $urandom_range(4, 0);
            repeat (gap) step();
        end
        distinct = 0;
        for (int i = 0; i < 11; i++) distinct += int'(seen[i]);
        check("rand_coverage", 32'(distinct), 32'd11);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_range_timer.md
# lfsr_range_timer

Parametrised random-duration countdown timer. On a start request it draws a pseudo-random start value from a free-running LFSR and maps it into the range [MIN_VAL, MIN_VAL+SPAN-1]. It then counts that value down at a prescaled tick rate, with pause, abort, retrigger mode, and a done pulse. It sits between game/control FSMs and the 7-segment/OLED display logic, and drives both the live count and the chosen start value.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 1: decrement rate; DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- CNT_W, 6: width of count/start_value.
- LFSR_W, 8: LFSR width.
- TAPS, 8'hB8: Galois feedback mask (x^8+x^6+x^5+x^4+1).
- SEED, 8'h5A: LFSR reset value, nonzero.
- MIN_VAL, 20: smallest start value, ≥ 1.
- SPAN, 11: number of possible start values, ≥ 1; MIN_VAL+SPAN-1 < 2^CNT_W.
- RETRIGGER, 0: 0 = start ignored while busy; 1 = start while busy restarts with a fresh random value.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request, sampled each cycle.
- pause  in  1  level; freezes prescaler and count while high.
- abort  in  1  stop immediately with no done pulse.
- count  out  CNT_W  current remaining value; 0 when idle.
- start_value  out  CNT_W  value captured at the last accepted start.
- busy  out  1  high while in RUN.
- tick  out  1  one-cycle pulse on each decrement.
- done  out  1  one-cycle pulse when count reaches 0 naturally.

## Operation
- **LFSR**
  - Galois LFSR advances every cycle regardless of state: lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : 0).
  - If lfsr is ever all-zero, the next value is SEED.
- **Mapping:** candidate = MIN_VAL + (lfsr mod SPAN), computed combinationally and sized to CNT_W. SPAN=1 gives a constant MIN_VAL.
- **States:** IDLE, RUN.
- **IDLE**
  - count = 0, busy = 0.
  - start=1 and abort=0 → start_value <= candidate, count <= candidate, prescaler <= 0, go to RUN.
- **RUN**
  - If pause=0: prescaler increments.
  - When prescaler = DIV-1: prescaler <= 0, tick = 1, count <= count-1.
  - If count was 1 at that tick: done = 1, go to IDLE.
  - If pause=1: prescaler, count and state hold; no tick.
- **Priority (highest first):** reset > abort > start (retrigger) > tick.
  - abort in RUN → IDLE next edge, count 0, no tick/done, start_value retained.
  - abort with start in IDLE → stay IDLE.
- **Retrigger**
  - RETRIGGER=0: start in RUN ignored.
  - RETRIGGER=1: start in RUN reloads candidate and clears prescaler. Same-cycle tick is suppressed and no done is issued, even if count was 1.
- **start_value** holds until the next accepted start. It is not cleared on abort or done.
- **Reset:** lfsr=SEED, state=IDLE, prescaler=0, count=0, start_value=0, busy=0, tick=0, done=0. Reset mid-RUN behaves the same, with no done.

## Timing
- All outputs registered except count in IDLE, which is forced to 0.
- Start accepted at edge E: busy=1, count=start_value=candidate(E) from E+1.
- First tick DIV cycles after E with no pause. Pause cycles extend the schedule 1:1.
- done asserts on the same cycle as the final tick. busy=0 and count=0 on the following cycle.
- Total RUN duration = start_value × DIV cycles plus pause cycles.
- start is level-sampled. Held high in IDLE, it restarts the cycle immediately after done (new value).

## Test plan
- Reset, then MIN_VAL=20, SPAN=1, DIV=10, start pulse → start_value=20, count=20 next cycle; tick every 10 cycles; count reaches 0 with done pulse at cycle 200; busy drops at 201.
- SPAN=11, 1000 starts at random times → every start_value in [20,30], matches the bench LFSR model cycle-exactly, and all 11 values appear.
- DIV=10, count=5, pause high for 37 cycles mid-period → no tick or count change during the pause; done delayed exactly 37 cycles.
- abort at count=3 → busy=0 and count=0 next cycle, no done, start_value unchanged; abort+start together in IDLE → stays IDLE.
- RETRIGGER=0 start at count=7 → ignored. RETRIGGER=1 start coincident with the final tick (count=1) → no done, count reloads to new candidate, prescaler restarts at 0.
- Synchronous reset asserted mid-RUN at count=12 → all outputs 0 on the next cycle, LFSR = SEED, no done.
